// File: rtl/fetch_sequencer.sv
// Purpose : program counter / fetch sequencer driven by the decoder's flow outputs and ALU flags.
// Latency : one cycle; inputs sampled at edge N set ProgCounter/InstrCount/state visible after edge N.
// Backpr. : none; the sequencer advances every RUN cycle and halts only on Ack.
//
// Ports
//   Clk, Reset        clock, synchronous active-high reset
//   Start             pulse: (re)start program at address 0 from IDLE or HALT
//   ConditionalJump   current instruction is a branch
//   BranchAbsOrRel    0 absolute target, 1 PC-relative target
//   BranchConditions  00 always, 01 Zero, 10 !Zero, 11 Negative
//   Ack               current instruction is the halt instruction
//   ZeroFlag, NegFlag registered ALU compare flags
//   BranchOperand     branch target / signed offset from the branch register
//   ProgCounter       instruction ROM address
//   Running, Done     registered state decodes (RUN, HALT)
//   InstrCount        saturating count of instructions executed since last Start
module fetch_sequencer #(
  parameter int PC_W  = 10,
  parameter int OP_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             ConditionalJump,
  input  logic             BranchAbsOrRel,
  input  logic [1:0]       BranchConditions,
  input  logic             Ack,
  input  logic             ZeroFlag,
  input  logic             NegFlag,
  input  logic [OP_W-1:0]  BranchOperand,
  output logic [PC_W-1:0]  ProgCounter,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc_q, pc_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             running_q, done_q;
  logic             cond_ok;
  logic [PC_W-1:0]  op_sext;
  logic [PC_W-1:0]  op_zext;

  // Size casts adapt the operand to the PC width: the signed cast sign-extends
  // (or truncates) for relative branches, the unsigned cast zero-extends.
  assign op_sext = PC_W'($signed(BranchOperand));
  assign op_zext = PC_W'(BranchOperand);

  // Flags are taken as they stand in the branch cycle; nothing is forwarded.
  always_comb begin
    cond_ok = 1'b1;
    case (BranchConditions)
      2'b00:   cond_ok = 1'b1;
      2'b01:   cond_ok = ZeroFlag;
      2'b10:   cond_ok = ~ZeroFlag;
      default: cond_ok = NegFlag;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    cnt_nxt   = cnt_q;
    case (state)
      S_IDLE: begin
        pc_nxt = '0;
        if (Start) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        // Start is deliberately ignored here: no restart mid-program.
        cnt_nxt = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        // The halt encoding also decodes as a branch, so Ack is tested first.
        if (Ack) begin
          state_nxt = S_HALT;
        end else if (ConditionalJump && cond_ok) begin
          pc_nxt = BranchAbsOrRel ? pc_q + op_sext : op_zext;
        end else begin
          pc_nxt = pc_q + PC_W'(1);
        end
      end
      S_HALT: begin
        if (Start) begin
          state_nxt = S_RUN;
          pc_nxt    = '0;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        pc_nxt    = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_nxt;
      cnt_q     <= cnt_nxt;
      // Decoded from the next state so the flags line up with the state register.
      running_q <= (state_nxt == S_RUN);
      done_q    <= (state_nxt == S_HALT);
    end
  end

  assign ProgCounter = pc_q;
  assign InstrCount  = cnt_q;
  assign Running     = running_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Purpose : self-checking bench for fetch_sequencer using a queue of expected per-cycle outputs.
// Latency : each driven cycle is checked #1 after the rising edge that consumed it.
// Backpr. : not applicable; stimulus is applied every cycle.
module tb_fetch_sequencer;

  localparam int PC_W  = 10;
  localparam int OP_W  = 8;
  localparam int CNT_W = 8;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             Start;
  logic             ConditionalJump;
  logic             BranchAbsOrRel;
  logic [1:0]       BranchConditions;
  logic             Ack;
  logic             ZeroFlag;
  logic             NegFlag;
  logic [OP_W-1:0]  BranchOperand;
  logic [PC_W-1:0]  ProgCounter;
  logic             Running;
  logic             Done;
  logic [CNT_W-1:0] InstrCount;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic             run;
    logic             done;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  typedef struct packed {
    logic            rst;
    logic            start;
    logic            cj;
    logic            rel;
    logic [1:0]      cond;
    logic            ack;
    logic            zero;
    logic            neg;
    logic [OP_W-1:0] op;
  } stim_t;

  obs_t sb[$];

  always #5 Clk = ~Clk;

  fetch_sequencer #(.PC_W(PC_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Start            (Start),
    .ConditionalJump  (ConditionalJump),
    .BranchAbsOrRel   (BranchAbsOrRel),
    .BranchConditions (BranchConditions),
    .Ack              (Ack),
    .ZeroFlag         (ZeroFlag),
    .NegFlag          (NegFlag),
    .BranchOperand    (BranchOperand),
    .ProgCounter      (ProgCounter),
    .Running          (Running),
    .Done             (Done),
    .InstrCount       (InstrCount)
  );

  function automatic obs_t ob(input int pc, input logic run, input logic done, input int cnt);
    obs_t o;
    o.pc   = PC_W'(pc);
    o.run  = run;
    o.done = done;
    o.cnt  = CNT_W'(cnt);
    return o;
  endfunction

  function automatic stim_t nop();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t br(input logic rel, input logic [1:0] cond, input logic z,
                               input logic n, input logic [OP_W-1:0] op);
    stim_t s = '0;
    s.cj = 1'b1; s.rel = rel; s.cond = cond; s.zero = z; s.neg = n; s.op = op;
    return s;
  endfunction

  // Applies one cycle of inputs and returns #1 after the consuming edge.
  task automatic drive(input stim_t s);
    Reset = s.rst; Start = s.start; ConditionalJump = s.cj; BranchAbsOrRel = s.rel;
    BranchConditions = s.cond; Ack = s.ack; ZeroFlag = s.zero; NegFlag = s.neg;
    BranchOperand = s.op;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t sq[$]; obs_t eq[$]; stim_t s; obs_t e, o;
    s = nop(); s.rst = 1'b1;               sq.push_back(s); eq.push_back(ob(0, 0, 0, 0));
    s.start = 1'b1;                         sq.push_back(s); eq.push_back(ob(0, 0, 0, 0));
    s = br(1'b0, 2'b00, 1'b0, 1'b0, 8'd50); sq.push_back(s); eq.push_back(ob(0, 0, 0, 0));
    sq.push_back(nop());                    eq.push_back(ob(0, 0, 0, 0));
    foreach (sq[i]) begin
      sb.push_back(eq[i]);
      drive(sq[i]);
      e = sb.pop_front();
      o = {ProgCounter, Running, Done, InstrCount};
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset[%0d]: got pc=%0d run=%b done=%b cnt=%0d, want pc=%0d run=%b done=%b cnt=%0d",
                 i, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  task automatic test_sequential();
    stim_t s; obs_t e, o;
    for (int i = 0; i <= 20; i++) begin
      s = nop(); s.start = (i == 0);
      sb.push_back(ob(i, 1, 0, i));
      drive(s);
      e = sb.pop_front();
      o = {ProgCounter, Running, Done, InstrCount};
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL sequential[%0d]: got pc=%0d run=%b done=%b cnt=%0d, want pc=%0d run=%b done=%b cnt=%0d",
                 i, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  // Entered at PC=20, count=20.
  task automatic test_branch_rel();
    stim_t sq[$]; obs_t eq[$]; obs_t e, o;
    sq.push_back(br(1'b1, 2'b01, 1'b1, 1'b0, 8'hFC)); eq.push_back(ob(16, 1, 0, 21));
    sq.push_back(br(1'b0, 2'b00, 1'b0, 1'b0, 8'd20)); eq.push_back(ob(20, 1, 0, 22));
    sq.push_back(br(1'b1, 2'b01, 1'b0, 1'b0, 8'hFC)); eq.push_back(ob(21, 1, 0, 23));
    foreach (sq[i]) begin
      sb.push_back(eq[i]);
      drive(sq[i]);
      e = sb.pop_front();
      o = {ProgCounter, Running, Done, InstrCount};
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL branch_rel[%0d]: got pc=%0d run=%b done=%b cnt=%0d, want pc=%0d run=%b done=%b cnt=%0d",
                 i, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  task automatic test_branch_abs();
    stim_t sq[$]; obs_t eq[$]; obs_t e, o;
    sq.push_back(br(1'b0, 2'b00, 1'b0, 1'b0, 8'd3));   eq.push_back(ob(3,   1, 0, 24));
    sq.push_back(br(1'b0, 2'b00, 1'b0, 1'b0, 8'd200)); eq.push_back(ob(200, 1, 0, 25));
    sq.push_back(br(1'b0, 2'b00, 1'b0, 1'b0, 8'd3));   eq.push_back(ob(3,   1, 0, 26));
    sq.push_back(br(1'b0, 2'b11, 1'b0, 1'b0, 8'd200)); eq.push_back(ob(4,   1, 0, 27));
    sq.push_back(br(1'b0, 2'b11, 1'b0, 1'b1, 8'd200)); eq.push_back(ob(200, 1, 0, 28));
    sq.push_back(br(1'b0, 2'b10, 1'b1, 1'b0, 8'd5));   eq.push_back(ob(201, 1, 0, 29));
    sq.push_back(br(1'b0, 2'b10, 1'b0, 1'b0, 8'd7));   eq.push_back(ob(7,   1, 0, 30));
    foreach (sq[i]) begin
      sb.push_back(eq[i]);
      drive(sq[i]);
      e = sb.pop_front();
      o = {ProgCounter, Running, Done, InstrCount};
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL branch_abs[%0d]: got pc=%0d run=%b done=%b cnt=%0d, want pc=%0d run=%b done=%b cnt=%0d",
                 i, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  // Wrap in both directions, Start ignored while running, zero-offset self-loop.
  task automatic test_wrap();
    stim_t sq[$]; obs_t eq[$]; stim_t s; obs_t e, o;
    sq.push_back(br(1'b0, 2'b00, 1'b0, 1'b0, 8'd2));   eq.push_back(ob(2,    1, 0, 31));
    sq.push_back(br(1'b1, 2'b00, 1'b0, 1'b0, 8'hFB));  eq.push_back(ob(1021, 1, 0, 32));
    sq.push_back(nop());                                eq.push_back(ob(1022, 1, 0, 33));
    sq.push_back(nop());                                eq.push_back(ob(1023, 1, 0, 34));
    sq.push_back(nop());                                eq.push_back(ob(0,    1, 0, 35));
    s = nop(); s.start = 1'b1;         sq.push_back(s); eq.push_back(ob(1,    1, 0, 36));
    sq.push_back(br(1'b1, 2'b00, 1'b0, 1'b0, 8'd0));   eq.push_back(ob(1,    1, 0, 37));
    sq.push_back(br(1'b1, 2'b00, 1'b0, 1'b0, 8'd0));   eq.push_back(ob(1,    1, 0, 38));
    foreach (sq[i]) begin
      sb.push_back(eq[i]);
      drive(sq[i]);
      e = sb.pop_front();
      o = {ProgCounter, Running, Done, InstrCount};
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL wrap[%0d]: got pc=%0d run=%b done=%b cnt=%0d, want pc=%0d run=%b done=%b cnt=%0d",
                 i, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  task automatic test_halt();
    stim_t sq[$]; obs_t eq[$]; stim_t s; obs_t e, o;
    sq.push_back(br(1'b0, 2'b00, 1'b0, 1'b0, 8'd7));   eq.push_back(ob(7, 1, 0, 39));
    s = br(1'b0, 2'b00, 1'b0, 1'b0, 8'd100); s.ack = 1'b1;
    sq.push_back(s);                                    eq.push_back(ob(7, 0, 1, 40));
    s = br(1'b1, 2'b00, 1'b0, 1'b0, 8'd5);
    sq.push_back(s);                                    eq.push_back(ob(7, 0, 1, 40));
    s.ack = 1'b1;
    sq.push_back(s);                                    eq.push_back(ob(7, 0, 1, 40));
    sq.push_back(nop());                                eq.push_back(ob(7, 0, 1, 40));
    s = nop(); s.start = 1'b1;         sq.push_back(s); eq.push_back(ob(0, 1, 0, 0));
    sq.push_back(nop());                                eq.push_back(ob(1, 1, 0, 1));
    foreach (sq[i]) begin
      sb.push_back(eq[i]);
      drive(sq[i]);
      e = sb.pop_front();
      o = {ProgCounter, Running, Done, InstrCount};
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL halt[%0d]: got pc=%0d run=%b done=%b cnt=%0d, want pc=%0d run=%b done=%b cnt=%0d",
                 i, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  // Entered at PC=1, count=1; runs past the counter maximum.
  task automatic test_saturation();
    int m_pc, m_cnt; obs_t e, o;
    m_pc = 1; m_cnt = 1;
    for (int i = 0; i < 300; i++) begin
      m_pc  = (m_pc + 1) % (1 << PC_W);
      m_cnt = (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
      sb.push_back(ob(m_pc, 1, 0, m_cnt));
      drive(nop());
      e = sb.pop_front();
      o = {ProgCounter, Running, Done, InstrCount};
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL saturation[%0d]: got pc=%0d run=%b done=%b cnt=%0d, want pc=%0d run=%b done=%b cnt=%0d",
                 i, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    stim_t sq[$]; obs_t eq[$]; stim_t s; obs_t e, o;
    sq.push_back(br(1'b0, 2'b00, 1'b0, 1'b0, 8'd50));  eq.push_back(ob(50, 1, 0, 255));
    s = br(1'b0, 2'b00, 1'b0, 1'b0, 8'd9); s.rst = 1'b1; s.start = 1'b1; s.ack = 1'b1;
    sq.push_back(s);                                    eq.push_back(ob(0, 0, 0, 0));
    sq.push_back(nop());                                eq.push_back(ob(0, 0, 0, 0));
    s = nop(); s.start = 1'b1;         sq.push_back(s); eq.push_back(ob(0, 1, 0, 0));
    sq.push_back(nop());                                eq.push_back(ob(1, 1, 0, 1));
    foreach (sq[i]) begin
      sb.push_back(eq[i]);
      drive(sq[i]);
      e = sb.pop_front();
      o = {ProgCounter, Running, Done, InstrCount};
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_mid_run[%0d]: got pc=%0d run=%b done=%b cnt=%0d, want pc=%0d run=%b done=%b cnt=%0d",
                 i, o.pc, o.run, o.done, o.cnt, e.pc, e.run, e.done, e.cnt);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch_rel();
    test_branch_abs();
    test_wrap();
    test_halt();
    test_saturation();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
